time_set_ctrl: RTL and testbench
================================

TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 SHALL have parameter DB_CYC, default 16, consecutive stable cycles for a debounced key edge.
REQ-002 SHALL have parameter IDLE_SEC, default 10, tick_1hz pulses without a press before auto-exit to RUN.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port key0  input  1  asynchronous active-low reset.
REQ-005 SHALL have port tick_1hz  input  1  one-cycle 1 Hz pulse from the timebase.
REQ-006 SHALL have port key1  input  1  raw active-low key, enter set mode or next field.
REQ-007 SHALL have port key2  input  1  raw active-low key, increment the selected field.
REQ-008 SHALL have port key3  input  1  raw active-low key, exit to RUN.
REQ-009 SHALL have port run_en  output  1  counting enable to the time/calendar datapath.
REQ-010 SHALL have port inc_pulse  output  1  one-cycle increment strobe.
REQ-011 SHALL have port inc_sel  output  3  field code: 1 hour, 2 min, 3 sec, 4 year, 5 month, 6 day, 0 none.
REQ-012 SHALL have port mode  output  3  current FSM state code.
REQ-013 SHALL have port date_view  output  1  display selects year/month/day.
REQ-014 SHALL have port blank_mask  output  3  per digit pair blank: [0] hex1:0, [1] hex3:2, [2] hex5:4.

Function
REQ-015 SHALL synchronise each raw key through 2 flops, then debounce: press event after DB_CYC consecutive low samples; re-arm only after DB_CYC consecutive high samples.
REQ-016 SHALL produce one press event per physical press; held keys never repeat.
REQ-017 SHALL implement states RUN(0), S_HOUR(1), S_MIN(2), S_SEC(3), S_YEAR(4), S_MON(5), S_DAY(6); codes 7 unreachable, recover to RUN.
REQ-018 SHALL on key1 event: RUN->S_HOUR->S_MIN->S_SEC->S_YEAR->S_MON->S_DAY->RUN.
REQ-019 SHALL on key3 event in any set state go to RUN; in RUN ignore it.
REQ-020 SHALL on key2 event in a set state assert inc_pulse for exactly one cycle with inc_sel = current field code; in RUN ignore key2.
REQ-021 SHALL resolve same-cycle events by priority key3 > key1 > key2; lower-priority events that cycle are discarded.
REQ-022 SHALL keep inc_sel = current field code in set states, 0 in RUN.
REQ-023 SHALL drive run_en = 1 only in RUN, 0 in all set states.
REQ-024 SHALL drive date_view = 1 in S_YEAR, S_MON, S_DAY, else 0.
REQ-025 SHALL toggle a blink phase on each tick_1hz in set states, clear it in RUN; blank_mask bit of the selected pair = phase, other bits 0 (sec/day bit0, min/month bit1, hour/year bit2).
REQ-026 SHALL count tick_1hz in set states with an idle counter, cleared by any accepted event and on entering a set state; at IDLE_SEC go to RUN.
REQ-027 SHALL let an accepted event in the same cycle as timeout win: event applied, counter cleared, no exit.
REQ-028 SHALL have latency: key low from cycle 0 and held -> event at cycle DB_CYC+2, registered outputs updated at cycle DB_CYC+3.

Reset
REQ-029 SHALL on key0 low asynchronously force: state RUN, run_en 1, inc_pulse 0, inc_sel 0, mode 0, date_view 0, blank_mask 0, phase 0, idle counter 0, sync flops 1, debounce counters 0 (released, armed).
REQ-030 SHALL, when reset asserts mid-press or mid-setting, emit no event until a fresh press after deassertion.

Structure
REQ-031 SHALL place state codes, field codes and DB_CYC/IDLE_SEC defaults in shared package clk_pkg.
REQ-032 SHALL use one sub-module key_debounce (sync + counter + edge), instantiated three times.

Verification
REQ-033 SHALL cover: DB_CYC=4, key1 low 3 cycles then high -> no event, mode stays 0.
REQ-034 SHALL cover: key1 press x7 from RUN -> mode 1,2,3,4,5,6,0; run_en 0 during 1..6, 1 at end; date_view 1 only at 4..6.
REQ-035 SHALL cover: in S_MIN, key2 held 100 cycles -> exactly one inc_pulse with inc_sel=2.
REQ-036 SHALL cover: key1, key2, key3 events same cycle in S_SEC -> mode 0, no inc_pulse.
REQ-037 SHALL cover: IDLE_SEC=3, enter S_HOUR, 3 ticks no press -> mode 0; repeat with key2 on 3rd tick cycle -> inc_pulse, stays S_HOUR.
REQ-038 SHALL cover: key0 low during S_DAY with key2 held -> all outputs at reset values; key2 still held after release -> no inc_pulse.

Source files
------------

// File: rtl/clk_pkg.sv
// rtl/clk_pkg.sv - shared state/field codes and parameter defaults for time setting
package clk_pkg;

    localparam int DB_CYC_DEF   = 16;
    localparam int IDLE_SEC_DEF = 10;

    typedef enum logic [2:0] {
        ST_RUN  = 3'd0,
        ST_HOUR = 3'd1,
        ST_MIN  = 3'd2,
        ST_SEC  = 3'd3,
        ST_YEAR = 3'd4,
        ST_MON  = 3'd5,
        ST_DAY  = 3'd6
    } state_t;

    localparam logic [2:0] FLD_NONE  = 3'd0;
    localparam logic [2:0] FLD_HOUR  = 3'd1;
    localparam logic [2:0] FLD_MIN   = 3'd2;
    localparam logic [2:0] FLD_SEC   = 3'd3;
    localparam logic [2:0] FLD_YEAR  = 3'd4;
    localparam logic [2:0] FLD_MONTH = 3'd5;
    localparam logic [2:0] FLD_DAY   = 3'd6;

    function automatic state_t next_field(input state_t s);
        case (s)
            ST_RUN:  return ST_HOUR;
            ST_HOUR: return ST_MIN;
            ST_MIN:  return ST_SEC;
            ST_SEC:  return ST_YEAR;
            ST_YEAR: return ST_MON;
            ST_MON:  return ST_DAY;
            default: return ST_RUN;
        endcase
    endfunction

    function automatic logic [2:0] field_of(input state_t s);
        case (s)
            ST_HOUR: return FLD_HOUR;
            ST_MIN:  return FLD_MIN;
            ST_SEC:  return FLD_SEC;
            ST_YEAR: return FLD_YEAR;
            ST_MON:  return FLD_MONTH;
            ST_DAY:  return FLD_DAY;
            default: return FLD_NONE;
        endcase
    endfunction

    // Bit 0 = hex1:0, bit 1 = hex3:2, bit 2 = hex5:4
    function automatic logic [2:0] blank_for(input state_t s, input logic phase);
        logic [2:0] m;
        case (s)
            ST_SEC, ST_DAY:   m = 3'b001;
            ST_MIN, ST_MON:   m = 3'b010;
            ST_HOUR, ST_YEAR: m = 3'b100;
            default:          m = 3'b000;
        endcase
        return phase ? m : 3'b000;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - two-flop synchroniser, debounce counter and press edge for one key
module key_debounce #(
    parameter int DB_CYC = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    output logic press
);
    localparam int CW = (DB_CYC > 1) ? $clog2(DB_CYC + 1) : 1;

    logic          s1, s2;
    logic          v1, v2;
    logic          live;
    logic          held;
    logic [CW-1:0] cnt;

    // live stays low until the key has been seen high after reset, so a key
    // held through reset cannot produce a press when reset is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1    <= 1'b1;
            s2    <= 1'b1;
            v1    <= 1'b0;
            v2    <= 1'b0;
            live  <= 1'b0;
            held  <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            s1    <= key;
            s2    <= s1;
            v1    <= 1'b1;
            v2    <= v1;
            press <= 1'b0;
            if (v2 && s2) begin
                live <= 1'b1;
            end
            if (!held) begin
                if (!s2 && live) begin
                    if (cnt == CW'(DB_CYC - 1)) begin
                        press <= 1'b1;
                        held  <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end else begin
                    cnt <= '0;
                end
            end else begin
                if (s2) begin
                    if (cnt == CW'(DB_CYC - 1)) begin
                        held <= 1'b0;
                        cnt  <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end else begin
                    cnt <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/time_set_ctrl.sv
// rtl/time_set_ctrl.sv - key-driven time/date setting mode controller
module time_set_ctrl
    import clk_pkg::*;
#(
    parameter int DB_CYC   = DB_CYC_DEF,
    parameter int IDLE_SEC = IDLE_SEC_DEF
) (
    input  logic       clk,
    input  logic       key0,
    input  logic       tick_1hz,
    input  logic       key1,
    input  logic       key2,
    input  logic       key3,
    output logic       run_en,
    output logic       inc_pulse,
    output logic [2:0] inc_sel,
    output logic [2:0] mode,
    output logic       date_view,
    output logic [2:0] blank_mask
);
    localparam int IW = (IDLE_SEC > 1) ? $clog2(IDLE_SEC + 1) : 1;

    logic ev1, ev2, ev3;

    key_debounce #(.DB_CYC(DB_CYC)) u_db1 (.clk(clk), .rst_n(key0), .key(key1), .press(ev1));
    key_debounce #(.DB_CYC(DB_CYC)) u_db2 (.clk(clk), .rst_n(key0), .key(key2), .press(ev2));
    key_debounce #(.DB_CYC(DB_CYC)) u_db3 (.clk(clk), .rst_n(key0), .key(key3), .press(ev3));

    state_t        state, state_nx;
    logic          phase, phase_nx;
    logic [IW-1:0] idle, idle_nx;
    logic          pulse_nx;

    always_comb begin
        state_nx = state;
        phase_nx = phase;
        idle_nx  = idle;
        pulse_nx = 1'b0;
        case (state)
            ST_RUN: begin
                if (ev1) state_nx = ST_HOUR;
            end
            ST_HOUR, ST_MIN, ST_SEC, ST_YEAR, ST_MON, ST_DAY: begin
                if (tick_1hz) phase_nx = ~phase;
                if (ev3)      state_nx = ST_RUN;
                else if (ev1) state_nx = next_field(state);
                else if (ev2) pulse_nx = 1'b1;
                // An accepted event beats a timeout landing in the same cycle
                if (ev1 || ev2 || ev3) begin
                    idle_nx = '0;
                end else if (tick_1hz) begin
                    if (idle == IW'(IDLE_SEC - 1)) state_nx = ST_RUN;
                    else                           idle_nx  = idle + 1'b1;
                end
            end
            default: state_nx = ST_RUN;
        endcase
        if (state_nx == ST_RUN) begin
            phase_nx = 1'b0;
            idle_nx  = '0;
        end
    end

    always_ff @(posedge clk or negedge key0) begin
        if (!key0) begin
            state      <= ST_RUN;
            phase      <= 1'b0;
            idle       <= '0;
            run_en     <= 1'b1;
            inc_pulse  <= 1'b0;
            inc_sel    <= FLD_NONE;
            mode       <= 3'd0;
            date_view  <= 1'b0;
            blank_mask <= 3'b000;
        end else begin
            state      <= state_nx;
            phase      <= phase_nx;
            idle       <= idle_nx;
            run_en     <= (state_nx == ST_RUN);
            inc_pulse  <= pulse_nx;
            inc_sel    <= field_of(state_nx);
            mode       <= state_nx;
            date_view  <= (state_nx == ST_YEAR) || (state_nx == ST_MON) || (state_nx == ST_DAY);
            blank_mask <= blank_for(state_nx, phase_nx);
        end
    end

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb/tb_time_set_ctrl.sv - scoreboard bench for time_set_ctrl
module tb_time_set_ctrl;

    logic       clk = 1'b0;
    logic       key0, tick_1hz, key1, key2, key3;
    logic       run_en, inc_pulse, date_view;
    logic [2:0] inc_sel, mode, blank_mask;

    int checks = 0;
    int errors = 0;

    logic [11:0] exp_q[$];
    string       name_q[$];
    logic        mon_en = 1'b0;

    time_set_ctrl #(.DB_CYC(4), .IDLE_SEC(3)) dut (
        .clk(clk), .key0(key0), .tick_1hz(tick_1hz),
        .key1(key1), .key2(key2), .key3(key3),
        .run_en(run_en), .inc_pulse(inc_pulse), .inc_sel(inc_sel),
        .mode(mode), .date_view(date_view), .blank_mask(blank_mask)
    );

    always #5 clk = ~clk;

    // {run_en, inc_pulse, inc_sel, mode, date_view, blank_mask}
    function automatic logic [11:0] mk(input logic r, input logic p, input logic [2:0] s,
                                       input logic [2:0] m, input logic d, input logic [2:0] b);
        return {r, p, s, m, d, b};
    endfunction

    localparam logic [11:0] RST_V = {1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 3'b000};

    // Steady set-mode vector: inc_sel equals the field code, which equals the mode code
    function automatic logic [11:0] sv(input logic [2:0] m, input logic p, input logic [2:0] b);
        return mk(m == 3'd0, p, m, m, (m >= 3'd4) && (m <= 3'd6), b);
    endfunction

    function automatic logic [11:0] cur_vec();
        return {run_en, inc_pulse, inc_sel, mode, date_view, blank_mask};
    endfunction

    task automatic expect_v(input logic [11:0] v, input string n);
        exp_q.push_back(v);
        name_q.push_back(n);
    endtask

    task automatic direct_chk(input string n, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic set_key(input int k, input logic v);
        case (k)
            1:       key1 = v;
            2:       key2 = v;
            default: key3 = v;
        endcase
    endtask

    task automatic press(input int k);
        @(posedge clk); #1;
        set_key(k, 1'b0);
        repeat (8) @(posedge clk);
        #1;
        set_key(k, 1'b1);
        repeat (8) @(posedge clk);
    endtask

    task automatic tick();
        @(posedge clk); #1 tick_1hz = 1'b1;
        @(posedge clk); #1 tick_1hz = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    // Monitor: every change of the output vector consumes one expected entry
    initial begin
        logic [11:0] prev, cur, e;
        string       n;
        prev = RST_V;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                cur = cur_vec();
                if (cur !== prev) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_change: got %h expected no change from %h", cur, prev);
                    end else begin
                        e = exp_q.pop_front();
                        n = name_q.pop_front();
                        if (cur !== e) begin
                            errors++;
                            $display("FAIL %s: got %h expected %h", n, cur, e);
                        end
                    end
                    prev = cur;
                end
            end
        end
    end

    initial begin
        key0 = 1'b0; key1 = 1'b1; key2 = 1'b1; key3 = 1'b1; tick_1hz = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        direct_chk("reset_outputs", cur_vec(), RST_V);
        key0 = 1'b1;
        mon_en = 1'b1;
        repeat (5) @(posedge clk);

        // Short glitch: 3 low cycles never reach DB_CYC=4
        @(posedge clk); #1 key1 = 1'b0;
        repeat (3) @(posedge clk);
        #1 key1 = 1'b1;
        repeat (10) @(posedge clk);

        // Full key1 cycle through all states
        for (int m = 1; m <= 7; m++) begin
            expect_v(sv(3'(m % 7), 1'b0, 3'b000), "key1_cycle");
            press(1);
        end

        // Held key2 in S_MIN gives a single increment
        expect_v(sv(3'd1, 1'b0, 3'b000), "to_hour");
        press(1);
        expect_v(sv(3'd2, 1'b0, 3'b000), "to_min");
        press(1);
        expect_v(sv(3'd2, 1'b1, 3'b000), "inc_min_on");
        expect_v(sv(3'd2, 1'b0, 3'b000), "inc_min_off");
        @(posedge clk); #1 key2 = 1'b0;
        repeat (100) @(posedge clk);
        #1 key2 = 1'b1;
        repeat (8) @(posedge clk);

        // Simultaneous key1/key2/key3 in S_SEC: key3 wins, no increment
        expect_v(sv(3'd3, 1'b0, 3'b000), "to_sec");
        press(1);
        expect_v(sv(3'd0, 1'b0, 3'b000), "triple_key_exit");
        @(posedge clk); #1 key1 = 1'b0; key2 = 1'b0; key3 = 1'b0;
        repeat (8) @(posedge clk);
        #1 key1 = 1'b1; key2 = 1'b1; key3 = 1'b1;
        repeat (8) @(posedge clk);

        // Idle timeout after IDLE_SEC=3 ticks, with hour-pair blink
        expect_v(sv(3'd1, 1'b0, 3'b000), "idle_enter_hour");
        press(1);
        expect_v(sv(3'd1, 1'b0, 3'b100), "blink_on_1");
        tick();
        expect_v(sv(3'd1, 1'b0, 3'b000), "blink_off_1");
        tick();
        expect_v(sv(3'd0, 1'b0, 3'b000), "idle_timeout");
        tick();

        // Same again, but key2 event lands on the third tick: event wins
        expect_v(sv(3'd1, 1'b0, 3'b000), "idle2_enter_hour");
        press(1);
        expect_v(sv(3'd1, 1'b0, 3'b100), "blink_on_2");
        tick();
        expect_v(sv(3'd1, 1'b0, 3'b000), "blink_off_2");
        tick();
        expect_v(sv(3'd1, 1'b1, 3'b100), "tick_vs_inc_on");
        expect_v(sv(3'd1, 1'b0, 3'b100), "tick_vs_inc_off");
        @(posedge clk); #1 key2 = 1'b0;
        repeat (6) @(posedge clk);
        #1 tick_1hz = 1'b1;
        @(posedge clk); #1 tick_1hz = 1'b0;
        repeat (4) @(posedge clk);
        #1 key2 = 1'b1;
        repeat (8) @(posedge clk);
        expect_v(sv(3'd0, 1'b0, 3'b000), "key3_exit");
        press(3);

        // Reset during S_DAY with key2 held; no increment afterwards
        for (int m = 1; m <= 6; m++) begin
            expect_v(sv(3'(m), 1'b0, 3'b000), "to_day");
            press(1);
        end
        @(posedge clk); #1 key2 = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        expect_v(RST_V, "async_reset");
        key0 = 1'b0;
        #1;
        direct_chk("reset_during_day", cur_vec(), RST_V);
        repeat (3) @(posedge clk);
        #1 key0 = 1'b1;
        repeat (30) @(posedge clk);
        #1 key2 = 1'b1;
        repeat (8) @(posedge clk);

        expect_v(sv(3'd1, 1'b0, 3'b000), "post_reset_key1");
        press(1);
        expect_v(sv(3'd0, 1'b0, 3'b000), "post_reset_key3");
        press(3);

        repeat (10) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_expected: got %0d outstanding expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
